// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared dimensions, state and tag types for the motion-estimation search controller
package me_pkg;

  localparam int MACRO_DIM  = 16;
  localparam int SEARCH_DIM = 48;
  localparam int SUM_LAT    = 2;
  localparam int NUM_OFS    = SEARCH_DIM - MACRO_DIM + 1;
  localparam int TAG_STAGES = 1 + SUM_LAT;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CPR,
    SEARCH,
    DRAIN,
    DONE
  } me_state_t;

  typedef struct packed {
    logic signed [5:0] x;
    logic signed [5:0] y;
  } mv_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] col;
    logic [5:0] row;
  } cand_tag_t;

  // Window position 0..32 to a displacement relative to the co-located block.
  function automatic logic signed [5:0] ofs_to_mv(input logic [5:0] pos);
    return $signed(pos - 6'(MACRO_DIM));
  endfunction

endpackage

// File: rtl/me_min_tracker.sv
// rtl/me_min_tracker.sv - candidate tag delay line aligned to the SAD latency, plus best-candidate hold
// Early-termination hit output is live only when ME_EARLY_TERM_EN is defined.
module me_min_tracker
  import me_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        tag_in_valid,
  input  logic [5:0]  tag_in_col,
  input  logic [5:0]  tag_in_row,
  input  logic [15:0] sad,
  input  logic [15:0] early_thr,
  output logic        hit,
  output logic [15:0] min_sad_nxt,
  output logic [5:0]  best_col_nxt,
  output logic [5:0]  best_row_nxt
);

  cand_tag_t   tag_q [TAG_STAGES];
  cand_tag_t   tag_d [TAG_STAGES];
  cand_tag_t   tag_exit;
  logic [15:0] min_q, min_d;
  logic [5:0]  best_col_q, best_col_d;
  logic [5:0]  best_row_q, best_row_d;
  logic        better;

  assign tag_exit = tag_q[TAG_STAGES-1];
  // Strict compare keeps the earliest candidate on ties.
  assign better   = tag_exit.valid && (sad < min_q);

  always_comb begin
    tag_d[0] = '{valid: tag_in_valid, col: tag_in_col, row: tag_in_row};
    for (int i = 1; i < TAG_STAGES; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    min_d      = min_q;
    best_col_d = best_col_q;
    best_row_d = best_row_q;
    if (init) begin
      min_d      = 16'hFFFF;
      best_col_d = '0;
      best_row_d = '0;
    end else if (better) begin
      min_d      = sad;
      best_col_d = tag_exit.col;
      best_row_d = tag_exit.row;
    end
  end

`ifdef ME_EARLY_TERM_EN
  assign hit = tag_exit.valid && (sad <= early_thr);
`else
  logic unused_thr;
  assign unused_thr = ^early_thr;
  assign hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_q[i] <= '0;
      end
      min_q      <= 16'hFFFF;
      best_col_q <= '0;
      best_row_q <= '0;
    end else begin
      tag_q      <= tag_d;
      min_q      <= min_d;
      best_col_q <= best_col_d;
      best_row_q <= best_row_d;
    end
  end

  assign min_sad_nxt  = min_d;
  assign best_col_nxt = best_col_d;
  assign best_row_nxt = best_row_d;

endmodule

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion-estimation sequencer for one macroblock
// Optional early termination on a good-enough SAD is enabled with ME_EARLY_TERM_EN.
module me_search_ctrl
  import me_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] early_thr,
  output logic        cpr_rd,
  output logic [3:0]  cpr_row,
  output logic        spr_rd,
  output logic [5:0]  spr_row,
  output logic [5:0]  spr_col,
  output logic        en_cpr,
  output logic        en_spr,
  input  logic [15:0] sad,
  output logic        busy,
  output logic        done,
  output logic [15:0] min_sad,
  output logic [5:0]  mv_x,
  output logic [5:0]  mv_y,
  output logic        early
);

  me_state_t   state_q, state_d;
  logic        cpr_rd_q, cpr_rd_d;
  logic [3:0]  cpr_row_q, cpr_row_d;
  logic        spr_rd_q, spr_rd_d;
  logic [5:0]  spr_row_q, spr_row_d;
  logic [5:0]  spr_col_q, spr_col_d;
  logic        en_cpr_q, en_cpr_d;
  logic        en_spr_q, en_spr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] min_sad_q, min_sad_d;
  logic [5:0]  mv_x_q, mv_x_d;
  logic [5:0]  mv_y_q, mv_y_d;
  logic        early_q, early_d;
  logic        early_term_q, early_term_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;

  logic        trk_init;
  logic        trk_hit;
  logic [15:0] trk_min_nxt;
  logic [5:0]  trk_col_nxt;
  logic [5:0]  trk_row_nxt;
  logic        tag_valid;
  logic [5:0]  tag_row;

  // The first MACRO_DIM-1 rows of each column only fill the matrix.
  assign tag_valid = spr_rd_q && (spr_row_q >= 6'(MACRO_DIM - 1));
  assign tag_row   = spr_row_q - 6'(MACRO_DIM - 1);

  me_min_tracker u_min_tracker (
    .clk          (clk),
    .rst          (rst),
    .init         (trk_init),
    .tag_in_valid (tag_valid),
    .tag_in_col   (spr_col_q),
    .tag_in_row   (tag_row),
    .sad          (sad),
    .early_thr    (early_thr),
    .hit          (trk_hit),
    .min_sad_nxt  (trk_min_nxt),
    .best_col_nxt (trk_col_nxt),
    .best_row_nxt (trk_row_nxt)
  );

  always_comb begin
    state_d      = state_q;
    cpr_rd_d     = cpr_rd_q;
    cpr_row_d    = cpr_row_q;
    spr_rd_d     = spr_rd_q;
    spr_row_d    = spr_row_q;
    spr_col_d    = spr_col_q;
    en_cpr_d     = cpr_rd_q;
    en_spr_d     = spr_rd_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    min_sad_d    = min_sad_q;
    mv_x_d       = mv_x_q;
    mv_y_d       = mv_y_q;
    early_d      = early_q;
    early_term_d = early_term_q;
    drain_cnt_d  = drain_cnt_q;
    trk_init     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD_CPR;
          cpr_rd_d     = 1'b1;
          cpr_row_d    = '0;
          busy_d       = 1'b1;
          early_term_d = 1'b0;
          trk_init     = 1'b1;
        end
      end
      LOAD_CPR: begin
        if (cpr_row_q == 4'(MACRO_DIM - 1)) begin
          state_d   = SEARCH;
          cpr_rd_d  = 1'b0;
          cpr_row_d = '0;
          spr_rd_d  = 1'b1;
          spr_row_d = '0;
          spr_col_d = '0;
        end else begin
          cpr_row_d = cpr_row_q + 4'd1;
        end
      end
      SEARCH: begin
        if (trk_hit || (spr_row_q == 6'(SEARCH_DIM - 1) && spr_col_q == 6'(NUM_OFS - 1))) begin
          state_d      = DRAIN;
          spr_rd_d     = 1'b0;
          spr_row_d    = '0;
          spr_col_d    = '0;
          drain_cnt_d  = '0;
          early_term_d = trk_hit;
        end else if (spr_row_q == 6'(SEARCH_DIM - 1)) begin
          spr_row_d = '0;
          spr_col_d = spr_col_q + 6'd1;
        end else begin
          spr_row_d = spr_row_q + 6'd1;
        end
      end
      DRAIN: begin
        // Latch the tracker's next value so the last in-flight tag is included.
        if (drain_cnt_q == 2'(SUM_LAT)) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          min_sad_d = trk_min_nxt;
          mv_x_d    = ofs_to_mv(trk_col_nxt);
          mv_y_d    = ofs_to_mv(trk_row_nxt);
          early_d   = early_term_q;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cpr_rd_q     <= 1'b0;
      cpr_row_q    <= '0;
      spr_rd_q     <= 1'b0;
      spr_row_q    <= '0;
      spr_col_q    <= '0;
      en_cpr_q     <= 1'b0;
      en_spr_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      min_sad_q    <= '0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
      early_q      <= 1'b0;
      early_term_q <= 1'b0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cpr_rd_q     <= cpr_rd_d;
      cpr_row_q    <= cpr_row_d;
      spr_rd_q     <= spr_rd_d;
      spr_row_q    <= spr_row_d;
      spr_col_q    <= spr_col_d;
      en_cpr_q     <= en_cpr_d;
      en_spr_q     <= en_spr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      min_sad_q    <= min_sad_d;
      mv_x_q       <= mv_x_d;
      mv_y_q       <= mv_y_d;
      early_q      <= early_d;
      early_term_q <= early_term_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign cpr_rd  = cpr_rd_q;
  assign cpr_row = cpr_row_q;
  assign spr_rd  = spr_rd_q;
  assign spr_row = spr_row_q;
  assign spr_col = spr_col_q;
  assign en_cpr  = en_cpr_q;
  assign en_spr  = en_spr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign min_sad = min_sad_q;
  assign mv_x    = mv_x_q;
  assign mv_y    = mv_y_q;
  assign early   = early_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - scoreboard bench for me_search_ctrl with a behavioural SAD datapath
`timescale 1ns/1ps
module tb_me_search_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] early_thr, sad;
  logic        cpr_rd, spr_rd, en_cpr, en_spr, busy, done, early;
  logic [3:0]  cpr_row;
  logic [5:0]  spr_row, spr_col, mv_x, mv_y;
  logic [15:0] min_sad;

  always #5 clk = ~clk;

  me_search_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .early_thr(early_thr),
    .cpr_rd(cpr_rd), .cpr_row(cpr_row), .spr_rd(spr_rd), .spr_row(spr_row), .spr_col(spr_col),
    .en_cpr(en_cpr), .en_spr(en_spr), .sad(sad), .busy(busy), .done(done),
    .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y), .early(early)
  );

  typedef struct {
    logic [15:0] min_sad;
    logic [5:0]  mv_x;
    logic [5:0]  mv_y;
    logic        early;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mode     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Datapath model: SAD for a read appears three cycles after the read strobe.
  logic       h_rd  [3] = '{1'b0, 1'b0, 1'b0};
  logic [5:0] h_row [3] = '{6'd0, 6'd0, 6'd0};
  logic [5:0] h_col [3] = '{6'd0, 6'd0, 6'd0};

  always @(posedge clk) begin
    h_rd[0]  <= spr_rd;  h_rd[1]  <= h_rd[0];  h_rd[2]  <= h_rd[1];
    h_row[0] <= spr_row; h_row[1] <= h_row[0]; h_row[2] <= h_row[1];
    h_col[0] <= spr_col; h_col[1] <= h_col[0]; h_col[2] <= h_col[1];
  end

  function automatic logic [15:0] model_sad(input int m, input int c, input int v);
    int dv, dc;
    dv = (v > 5) ? v - 5 : 5 - v;
    dc = (c > 20) ? c - 20 : 20 - c;
    case (m)
      1:       return 16'(dv + 2 * dc);
      2:       return 16'd100;
      3:       return (c == 3 && v == 7) ? 16'd40 : 16'd1000;
      4:       return 16'(2000 - 33 * c - v);
      default: return 16'd0;
    endcase
  endfunction

  always_comb begin
    sad = 16'd0;
    if (h_rd[2] && h_row[2] >= 6'd15) sad = model_sad(mode, int'(h_col[2]), int'(h_row[2]) - 15);
  end

  // Monitor: latency measured from the cycle start is seen in IDLE.
  int   cyc = 0;
  int   start_cyc = 0;
  int   lag_err = 0;
  logic prev_cpr_rd = 1'b0, prev_spr_rd = 1'b0, prev_rst = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (start && !busy && !done && !rst) start_cyc = cyc;
    if (!prev_rst && (en_cpr !== prev_cpr_rd || en_spr !== prev_spr_rd)) lag_err++;
    prev_cpr_rd = cpr_rd;
    prev_spr_rd = spr_rd;
    prev_rst    = rst;
    if (done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("min_sad", 32'(min_sad), 32'(mon_e.min_sad));
        check("mv_x", 32'(mv_x), 32'(mon_e.mv_x));
        check("mv_y", 32'(mv_y), 32'(mon_e.mv_y));
        check("early", 32'(early), 32'(mon_e.early));
        check("done_latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] m, input logic [5:0] x, input logic [5:0] y,
                          input logic e, input int lat);
    exp_t t;
    t.min_sad = m; t.mv_x = x; t.mv_y = y; t.early = e; t.lat = lat;
    exp_q.push_back(t);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  total_rd, late_rd, rel;
    bit  found;
    rst = 1'b1; start = 1'b0; early_thr = 16'd0; mode = 0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", 32'(|{cpr_rd, cpr_row, spr_rd, spr_row, spr_col, en_cpr, en_spr,
                                  busy, done, min_sad, mv_x, mv_y, early}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Constant SAD: tie keeps the first candidate; also checks load sequence and done timing.
    mode = 2;
    push_exp(16'd100, 6'(-16), 6'(-16), 1'b0, 1604);
    run_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("cpr_rd", 32'(cpr_rd), 32'd1);
      check("cpr_row", 32'(cpr_row), 32'(i));
      if (i == 0) check("busy_load", 32'(busy), 32'd1);
      if (i == 1) check("en_cpr_lag", 32'(en_cpr), 32'd1);
    end
    @(negedge clk);
    check("cpr_rd_end", 32'(cpr_rd), 32'd0);
    check("spr_rd_first", 32'(spr_rd), 32'd1);
    check("spr_addr_first", 32'({spr_col, spr_row}), 32'd0);
    wait_done("t1_done_timeout");
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("min_sad_held", 32'(min_sad), 32'd100);
    check("busy_after_done", 32'(busy), 32'd0);
    tick();

    // Diamond-shaped cost with unique zero at c=20, v=5.
    mode = 1;
`ifdef ME_EARLY_TERM_EN
    push_exp(16'd0, 6'd4, 6'(-11), 1'b1, 1004);
`else
    push_exp(16'd0, 6'd4, 6'(-11), 1'b0, 1604);
`endif
    run_start();
    wait_done("t2_done_timeout");
    tick();

    // Reset mid-search at column 10, then a clean rerun.
    mode = 2;
    run_start();
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (spr_rd && spr_col == 6'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_col10", 32'(found), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'(|{cpr_rd, cpr_row, spr_rd, spr_row, spr_col, en_cpr, en_spr,
                                busy, done, min_sad, mv_x, mv_y, early}), 32'd0);
    tick();
    push_exp(16'd100, 6'(-16), 6'(-16), 1'b0, 1604);
    run_start();
    wait_done("t4_done_timeout");
    tick();

    // Minimum at the last candidate; a start pulse mid-search must be ignored.
    mode = 4;
    push_exp(16'd912, 6'd16, 6'd16, 1'b0, 1604);
    run_start();
    repeat (300) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done_timeout");
    tick();

    // Single good candidate at c=3, v=7 with threshold 50.
    mode = 3;
    early_thr = 16'd50;
`ifdef ME_EARLY_TERM_EN
    push_exp(16'd40, 6'(-13), 6'(-9), 1'b1, 190);
`else
    push_exp(16'd40, 6'(-13), 6'(-9), 1'b0, 1604);
`endif
    run_start();
    total_rd = 0; late_rd = 0; rel = 0; found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rel++;
      if (spr_rd) total_rd++;
      if (spr_rd && rel > 187) late_rd++;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_done_timeout", 32'(found), 32'd1);
`ifdef ME_EARLY_TERM_EN
    check("t6_late_spr_rd", 32'(late_rd), 32'd0);
    check("t6_total_spr_rd", 32'(total_rd), 32'd170);
`else
    check("t6_total_spr_rd", 32'(total_rd), 32'd1584);
`endif
    tick();
    early_thr = 16'd0;

    repeat (4) tick();
    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("en_lag_errors", 32'(lag_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
